// File: rtl/vga_timing_gen_pkg.sv
// Shared raster-timing constants and helpers for the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam bit SYNC_POL_LOW  = 1'b0;
  localparam bit SYNC_POL_HIGH = 1'b1;

  function automatic int unsigned axis_total(input int unsigned vis, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

  function automatic int unsigned axis_width(input int unsigned total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: wrapping position counter plus decode of its next value.
module timing_axis_counter import vga_timing_pkg::*; #(
  parameter  int unsigned TOTAL   = 800,
  parameter  int unsigned VISIBLE = 640,
  parameter  int unsigned SYNC_LO = 656,
  parameter  int unsigned SYNC_HI = 752,
  localparam int unsigned W       = axis_width(TOTAL)
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         run,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         vis_nxt,
  output logic         sync_nxt,
  output logic         zero_nxt
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] count_nxt;

  function automatic logic in_window(input logic [W-1:0] v, input logic [W-1:0] lo,
                                     input logic [W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  assign tc = (count == LAST);

  always_comb begin
    count_nxt = count;
    if (run && inc) count_nxt = tc ? '0 : count + W'(1);
  end

  // Flags are decoded from the value about to be loaded so they register alongside it.
  assign vis_nxt  = (count_nxt < W'(VISIBLE));
  assign sync_nxt = in_window(count_nxt, W'(SYNC_LO), W'(SYNC_HI));
  assign zero_nxt = (count_nxt == '0);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count_nxt;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: sync, position, visible/blank flags and strobes,
// all registered on the same edge as the position counters.
module vga_timing_gen import vga_timing_pkg::*; #(
  parameter  int unsigned H_VISIBLE        = DEF_H_VISIBLE,
  parameter  int unsigned H_FRONT          = DEF_H_FRONT,
  parameter  int unsigned H_SYNC           = DEF_H_SYNC,
  parameter  int unsigned H_BACK           = DEF_H_BACK,
  parameter  int unsigned V_VISIBLE        = DEF_V_VISIBLE,
  parameter  int unsigned V_FRONT          = DEF_V_FRONT,
  parameter  int unsigned V_SYNC           = DEF_V_SYNC,
  parameter  int unsigned V_BACK           = DEF_V_BACK,
  parameter  bit          SYNC_ACTIVE_HIGH = SYNC_POL_LOW,
  localparam int unsigned H_TOTAL          = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK),
  localparam int unsigned V_TOTAL          = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK),
  localparam int unsigned HW               = axis_width(H_TOTAL),
  localparam int unsigned VW               = axis_width(V_TOTAL)
) (
  input  logic          clk_in,
  input  logic          rst_n,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          visible,
  output logic          vblank,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_count
);

  if (H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_VISIBLE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_param_err
    $error("vga_timing_gen: visible, porch and sync parameters must all be non-zero");
  end

  localparam logic SYNC_ON  = SYNC_ACTIVE_HIGH ? SYNC_POL_HIGH : SYNC_POL_LOW;
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic running;
  logic h_tc, h_vis_nxt, h_sync_nxt, h_zero_nxt;
  logic v_tc, v_vis_nxt, v_sync_nxt, v_zero_nxt;

  timing_axis_counter #(
    .TOTAL  (H_TOTAL),
    .VISIBLE(H_VISIBLE),
    .SYNC_LO(H_VISIBLE + H_FRONT),
    .SYNC_HI(H_VISIBLE + H_FRONT + H_SYNC)
  ) u_h_axis (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .run     (running),
    .inc     (1'b1),
    .count   (hcount),
    .tc      (h_tc),
    .vis_nxt (h_vis_nxt),
    .sync_nxt(h_sync_nxt),
    .zero_nxt(h_zero_nxt)
  );

  timing_axis_counter #(
    .TOTAL  (V_TOTAL),
    .VISIBLE(V_VISIBLE),
    .SYNC_LO(V_VISIBLE + V_FRONT),
    .SYNC_HI(V_VISIBLE + V_FRONT + V_SYNC)
  ) u_v_axis (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .run     (running),
    .inc     (h_tc),
    .count   (vcount),
    .tc      (v_tc),
    .vis_nxt (v_vis_nxt),
    .sync_nxt(v_sync_nxt),
    .zero_nxt(v_zero_nxt)
  );

  // The first edge after reset only arms the counters, presenting pixel (0,0) as frame 0.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      running     <= 1'b0;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      visible     <= 1'b0;
      vblank      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      running     <= 1'b1;
      hsync       <= h_sync_nxt ? SYNC_ON : SYNC_OFF;
      vsync       <= v_sync_nxt ? SYNC_ON : SYNC_OFF;
      visible     <= h_vis_nxt & v_vis_nxt;
      vblank      <= ~v_vis_nxt;
      line_start  <= h_zero_nxt;
      frame_start <= h_zero_nxt & v_zero_nxt;
      if (running && h_tc && v_tc) frame_count <= frame_count + 16'd1;
    end
  end

endmodule
